// File: rtl/rtc_sched_pkg.sv
// Shared constants and FSM state encoding for the RTC alarm scheduler.
package rtc_sched_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_CNT_WIDTH = 32;

    // Scheduler states: nothing pending, walking the slots, holding a valid next alarm.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ARMED = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rtc_alarm_sched_if.sv
// Per-requester alarm request / cancel handshake bundle.
interface rtc_alarm_sched_if
    import rtc_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] req_time_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic [NUM_REQ-1:0]                req_cancel_i;

    modport master (
        output req_valid_i,
        output req_time_i,
        output req_cancel_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_time_i,
        input  req_cancel_i,
        output req_ready_o
    );

endinterface

// File: rtl/rtc_sched_slot.sv
// One alarm slot: stores {pending, time}, handles accept / cancel, and
// compares its time against the live counter every cycle.
module rtc_sched_slot
    import rtc_sched_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 req_valid,
    input  logic [CNT_WIDTH-1:0] req_time,
    input  logic                 cancel,
    output logic                 ready,
    output logic                 pending,
    output logic [CNT_WIDTH-1:0] alarm_time,
    output logic                 fire,
    output logic                 change
);

    logic accept;
    logic drop;
    logic match;

    assign ready  = ~pending;
    assign accept = ~pending & req_valid;
    assign drop   = pending & cancel;
    assign match  = pending & (cnt == alarm_time);
    // Any of these alters the pending set on the next edge and forces a rescan.
    assign change = accept | drop | match;

    // Slot state update; a cancel wins over a same-cycle match and suppresses the fire.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending    <= 1'b0;
            // NOTE: alarm_time is only meaningful while pending, but it is a handful of
            // flops rather than a RAM, so resetting it costs nothing and keeps outputs clean.
            alarm_time <= '0;
            fire       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fire <= match & ~cancel;
            if (accept) begin
                pending    <= 1'b1;
                alarm_time <= req_time;
            end else if (drop || match) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rtc_alarm_sched.sv
// RTC alarm scheduler: NUM_REQ alarm slots plus a sequential min-finder that
// reports the earliest pending alarm relative to the counter at scan start.
module rtc_alarm_sched
    import rtc_sched_pkg::*;
#(
    parameter int  NUM_REQ   = DEF_NUM_REQ,
    parameter int  CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    rtc_alarm_sched_if.slave     req_if,
    output logic [NUM_REQ-1:0]   fire_o,
    output logic                 irq_o,
    output logic                 next_vld_o,
    output logic [CNT_WIDTH-1:0] next_time_o,
    output logic [IDX_W-1:0]     next_idx_o,
    output logic                 busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]                pending;
    logic [NUM_REQ-1:0]                change;
    logic [NUM_REQ-1:0]                ready;
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] alarm_time;
    logic                              set_change;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        rtc_sched_slot #(.CNT_WIDTH(CNT_WIDTH)) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .cnt        (cnt_i),
            .req_valid  (req_if.req_valid_i[g]),
            .req_time   (req_if.req_time_i[g]),
            .cancel     (req_if.req_cancel_i[g]),
            .ready      (ready[g]),
            .pending    (pending[g]),
            .alarm_time (alarm_time[g]),
            .fire       (fire_o[g]),
            .change     (change[g])
        );
    end

    assign req_if.req_ready_o = ready;
    assign irq_o              = |fire_o;
    assign set_change         = |change;

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
    logic [CNT_WIDTH-1:0]   snap_q, snap_d, snap;
    logic                   best_vld_q, best_vld_d;
    logic [CNT_WIDTH-1:0]   best_dist_q, best_dist_d;
    logic [IDX_W-1:0]       best_idx_q, best_idx_d;
    logic                   next_vld_d;
    logic [CNT_WIDTH-1:0]   next_time_d;
    logic [IDX_W-1:0]       next_idx_d;
    logic                   fresh, take, cand_vld;
    logic [CNT_WIDTH-1:0]   visit_dist, cand_dist;
    logic [IDX_W-1:0]       cand_idx;

    assign busy_o = (state_q == SCAN);

    // Scan datapath and next-state logic; slot 0 uses the live counter as the snapshot.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        snap_d      = snap_q;
        best_vld_d  = best_vld_q;
        best_dist_d = best_dist_q;
        best_idx_d  = best_idx_q;
        next_vld_d  = next_vld_o;
        next_time_d = next_time_o;
        next_idx_d  = next_idx_o;

        fresh      = (scan_idx_q == '0);
        snap       = fresh ? cnt_i : snap_q;
        visit_dist = alarm_time[scan_idx_q] - snap;
        // Strict compare while walking upward keeps ties on the lowest index.
        take       = pending[scan_idx_q] &
                     (fresh | ~best_vld_q | (visit_dist < best_dist_q));
        cand_vld   = take | (~fresh & best_vld_q);
        cand_dist  = take ? visit_dist : best_dist_q;
        cand_idx   = take ? scan_idx_q : best_idx_q;

        unique case (state_q)
            IDLE, ARMED: begin
                if (set_change) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                end
            end
            SCAN: begin
                if (set_change) begin
                    scan_idx_d = '0;
                end else begin
                    snap_d      = snap;
                    best_vld_d  = cand_vld;
                    best_dist_d = cand_dist;
                    best_idx_d  = cand_idx;
                    if (scan_idx_q == LAST_IDX) begin
                        if (cand_vld) begin
                            state_d     = ARMED;
                            next_vld_d  = 1'b1;
                            next_time_d = alarm_time[cand_idx];
                            next_idx_d  = cand_idx;
                        end else begin
                            state_d    = IDLE;
                            next_vld_d = 1'b0;
                        end
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, scan bookkeeping and next-alarm output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            scan_idx_q  <= '0;
            snap_q      <= '0;
            best_vld_q  <= 1'b0;
            best_dist_q <= '0;
            best_idx_q  <= '0;
            next_vld_o  <= 1'b0;
            next_time_o <= '0;
            next_idx_o  <= '0;
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            snap_q      <= snap_d;
            best_vld_q  <= best_vld_d;
            best_dist_q <= best_dist_d;
            best_idx_q  <= best_idx_d;
            next_vld_o  <= next_vld_d;
            next_time_o <= next_time_d;
            next_idx_o  <= next_idx_d;
        end
    end

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// Scoreboard bench for rtc_alarm_sched: a cycle-level reference model derived
// from the slot rules queues expected fires and scan results; a monitor pops them.
module tb_rtc_alarm_sched;
    import rtc_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  cnt = '0;
    logic [N-1:0]  fire;
    logic          irq, next_vld, busy;
    logic [W-1:0]  next_time;
    logic [IW-1:0] next_idx;

    rtc_alarm_sched_if #(.NUM_REQ(N), .CNT_WIDTH(W)) req_if ();

    rtc_alarm_sched #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cnt_i       (cnt),
        .req_if      (req_if.slave),
        .fire_o      (fire),
        .irq_o       (irq),
        .next_vld_o  (next_vld),
        .next_time_o (next_time),
        .next_idx_o  (next_idx),
        .busy_o      (busy)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct { int c; logic [N-1:0] vec; } fire_exp_t;
    typedef struct { int c; bit vld; logic [IW-1:0] idx; logic [W-1:0] tm; } next_exp_t;

    fire_exp_t fire_q[$];
    next_exp_t next_q[$];

    // Reference model state
    logic [N-1:0] m_pend = '0;
    logic [W-1:0] m_time [N];
    logic [W-1:0] m_snap = '0;
    bit           scan_active = 1'b0;
    int           scan_start = 0;
    logic [N-1:0] exp_ready = '1;
    bit           prev_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Earliest pending alarm measured forward from the scan snapshot.
    function automatic next_exp_t model_next(input int c);
        next_exp_t r;
        logic [W-1:0] d, best;
        r.c = c; r.vld = 1'b0; r.idx = '0; r.tm = '0; best = '0;
        for (int i = 0; i < N; i++) begin
            d = m_time[i] - m_snap;
            if (m_pend[i] && (!r.vld || d < best)) begin
                r.vld = 1'b1; r.idx = IW'(i); r.tm = m_time[i]; best = d;
            end
        end
        return r;
    endfunction

    // Advance the model across one clock edge using the inputs the DUT just latched.
    task automatic step();
        logic [N-1:0] fv;
        bit chg;
        @(posedge clk);
        #1;
        fv = '0;
        chg = 1'b0;
        if (scan_active && (cyc - 1 == scan_start)) m_snap = cnt;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) begin
                if (req_if.req_cancel_i[i]) begin
                    m_pend[i] = 1'b0; chg = 1'b1;
                end else if (cnt == m_time[i]) begin
                    m_pend[i] = 1'b0; fv[i] = 1'b1; chg = 1'b1;
                end
            end else if (req_if.req_valid_i[i]) begin
                m_pend[i] = 1'b1; m_time[i] = req_if.req_time_i[i]; chg = 1'b1;
            end
        end
        if (fv != '0) fire_q.push_back('{cyc, fv});
        if (chg) begin
            scan_active = 1'b1;
            scan_start  = cyc;
        end else if (scan_active && cyc == scan_start + N) begin
            next_q.push_back(model_next(cyc));
            scan_active = 1'b0;
        end
        exp_ready = ~m_pend;
    endtask

    task automatic tick(input bit inc);
        step();
        req_if.req_valid_i  = '0;
        req_if.req_cancel_i = '0;
        if (inc) cnt = cnt + 1'b1;
    endtask

    task automatic request(input int slot, input logic [W-1:0] t);
        req_if.req_valid_i[slot] = 1'b1;
        req_if.req_time_i[slot]  = t;
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic do_reset(input logic [W-1:0] new_cnt);
        #2 rst = 1'b1;
        #1;
        check("rst_fire",      64'(fire),                 64'(0));
        check("rst_irq",       64'(irq),                  64'(0));
        check("rst_next_vld",  64'(next_vld),             64'(0));
        check("rst_next_time", 64'(next_time),            64'(0));
        check("rst_next_idx",  64'(next_idx),             64'(0));
        check("rst_busy",      64'(busy),                 64'(0));
        check("rst_ready",     64'(req_if.req_ready_o),   64'({N{1'b1}}));
        m_pend = '0;
        scan_active = 1'b0;
        fire_q.delete();
        next_q.delete();
        exp_ready = '1;
        req_if.req_valid_i  = '0;
        req_if.req_cancel_i = '0;
        cnt = new_cnt;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs against queued expectations, sampled mid-cycle.
    initial begin
        fire_exp_t fe;
        next_exp_t ne;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                continue;
            end
            check("ready", 64'(req_if.req_ready_o), 64'(exp_ready));
            if (fire != '0) begin
                if (fire_q.size() == 0) begin
                    check("fire_unexpected", 64'(fire), 64'(0));
                end else begin
                    fe = fire_q.pop_front();
                    check("fire_cycle", 64'(cyc),  64'(fe.c));
                    check("fire_vec",   64'(fire), 64'(fe.vec));
                    check("irq_on",     64'(irq),  64'(1));
                end
            end else begin
                check("irq_quiet", 64'(irq), 64'(0));
                if (fire_q.size() > 0 && fire_q[0].c <= cyc) begin
                    fe = fire_q.pop_front();
                    check("fire_missing", 64'(0), 64'(fe.vec));
                end
            end
            if (prev_busy && !busy) begin
                if (next_q.size() == 0) begin
                    check("scan_end_unexpected", 64'(1), 64'(0));
                end else begin
                    ne = next_q.pop_front();
                    check("scan_end_cycle", 64'(cyc),      64'(ne.c));
                    check("next_vld",       64'(next_vld), 64'(ne.vld));
                    if (ne.vld) begin
                        check("next_idx",  64'(next_idx),  64'(ne.idx));
                        check("next_time", 64'(next_time), 64'(ne.tm));
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_if.req_valid_i  = '0;
        req_if.req_cancel_i = '0;
        req_if.req_time_i   = '0;

        // Single alarm: slot1 at 105 from cnt 100
        do_reset(32'd100);
        request(1, 32'd105);
        tick(1'b0);
        for (int k = 0; k < 12; k++) tick(1'b1);

        // Equal times fire together, then rescan picks the remaining slot
        do_reset(32'd10);
        request(0, 32'd50);
        request(2, 32'd20);
        request(3, 32'd20);
        tick(1'b0);
        for (int k = 0; k < 48; k++) tick(1'b1);

        // Wrap-aware ordering around the counter rollover
        do_reset(32'hFFFF_FFF0);
        request(0, 32'h0000_0005);
        request(1, 32'hFFFF_FFFA);
        tick(1'b0);
        for (int k = 0; k < 30; k++) tick(1'b1);

        // Cancel in the match cycle suppresses the fire
        do_reset(32'd20);
        request(0, 32'd30);
        tick(1'b0);
        for (int k = 0; k < 20 && cnt != 32'd30; k++) tick(1'b1);
        req_if.req_cancel_i[0] = 1'b1;
        tick(1'b1);
        for (int k = 0; k < 8; k++) tick(1'b1);

        // Accept during SCAN restarts the scan
        do_reset(32'd200);
        request(0, 32'd300);
        tick(1'b0);
        tick(1'b0);
        request(3, 32'd250);
        tick(1'b0);
        for (int k = 0; k < 8; k++) tick(1'b1);

        // Reset while ARMED drops the alarm even if the counter then matches
        do_reset(32'd400);
        request(2, 32'd410);
        tick(1'b0);
        for (int k = 0; k < 6; k++) tick(1'b1);
        do_reset(32'd409);
        for (int k = 0; k < 6; k++) tick(1'b1);

        // Randomized traffic across a counter wrap
        do_reset(32'hFFFF_FE80);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom % 6 == 0) begin
                    if ($urandom % 10 == 0)
                        request(i, cnt - W'($urandom_range(1, 5)));
                    else
                        request(i, cnt + W'($urandom_range(0, 30)));
                end
                if ($urandom % 25 == 0) req_if.req_cancel_i[i] = 1'b1;
            end
            tick($urandom % 10 < 7);
        end
        for (int k = 0; k < 10; k++) tick(1'b0);

        @(negedge clk);
        #1;
        check("fire_queue_drained", 64'(fire_q.size()), 64'(0));
        check("next_queue_drained", 64'(next_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
